// File: rtl/cobs_stream_arbiter.sv
// Round-robin packet arbiter sharing one AXI-Stream path between NUM_SOURCES sources.
// Define COBS_ARB_HEADER_EN to prefix each packet with a {8'hA5, grant_id} channel header.
module cobs_stream_arbiter #(
   parameter int unsigned NUM_SOURCES = 4,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned MAX_BEATS   = 64,
   parameter int unsigned ID_WIDTH    = $clog2(NUM_SOURCES)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_tdata,
   input  logic [NUM_SOURCES-1:0]            s_tvalid,
   input  logic [NUM_SOURCES-1:0]            s_tlast,
   output logic [NUM_SOURCES-1:0]            s_tready,
   output logic [DATA_WIDTH-1:0]             m_tdata,
   output logic                              m_tvalid,
   output logic                              m_tlast,
   input  logic                              m_tready,
   output logic [ID_WIDTH-1:0]               grant_id,
   output logic                              busy,
   output logic                              overflow
);

   localparam int unsigned CNT_WIDTH = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_BEATS - 1);

`ifdef COBS_ARB_HEADER_EN
   typedef enum logic [1:0] {StIdle, StHdr, StPass} state_e;
`else
   typedef enum logic [0:0] {StIdle, StPass} state_e;
`endif

   state_e                 state;
   logic [ID_WIDTH-1:0]    rr_ptr;
   logic [CNT_WIDTH-1:0]   beat_cnt;
   logic                   found;
   logic [ID_WIDTH-1:0]    winner;
   logic [ID_WIDTH-1:0]    cand;
   logic [DATA_WIDTH-1:0]  sel_data;
   logic                   sel_valid;
   logic                   sel_last;
   logic                   at_limit;
   logic                   xfer;

   // Cyclic search starting just after the last winner.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int unsigned k = 1; k <= NUM_SOURCES; k++) begin
         cand = ID_WIDTH'((32'(rr_ptr) + k) % NUM_SOURCES);
         if (!found && s_tvalid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (grant_id == ID_WIDTH'(i)) begin
            sel_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_valid = s_tvalid[i];
            sel_last  = s_tlast[i];
         end
      end
   end

   assign at_limit = (beat_cnt == LAST_CNT);

   always_comb begin
      m_tdata  = '0;
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
      s_tready = '0;
      case (state)
`ifdef COBS_ARB_HEADER_EN
         StHdr: begin
            m_tvalid = 1'b1;
            m_tdata  = DATA_WIDTH'({8'hA5, 8'(grant_id)});
         end
`endif
         StPass: begin
            m_tdata  = sel_data;
            m_tvalid = sel_valid;
            m_tlast  = sel_last | at_limit;
            for (int i = 0; i < NUM_SOURCES; i++) begin
               s_tready[i] = m_tready && (grant_id == ID_WIDTH'(i));
            end
         end
         default: ;
      endcase
   end

   assign xfer = m_tvalid && m_tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= StIdle;
         rr_ptr   <= ID_WIDTH'(NUM_SOURCES - 1);
         grant_id <= '0;
         beat_cnt <= '0;
         busy     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (found) begin
                  grant_id <= winner;
                  rr_ptr   <= winner;
                  beat_cnt <= '0;
                  busy     <= 1'b1;
`ifdef COBS_ARB_HEADER_EN
                  state    <= StHdr;
`else
                  state    <= StPass;
`endif
               end
            end
`ifdef COBS_ARB_HEADER_EN
            StHdr: begin
               if (m_tready) state <= StPass;
            end
`endif
            StPass: begin
               if (xfer) begin
                  if (m_tlast) begin
                     state <= StIdle;
                     busy  <= 1'b0;
                     // tlast came from the beat limit, not the source
                     if (!sel_last) overflow <= 1'b1;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_cobs_stream_arbiter.sv
// Scoreboard bench for cobs_stream_arbiter: expected beats are queued as packets are
// offered and compared as they leave m_*.
module tb_cobs_stream_arbiter;

   localparam int unsigned NS = 4;
   localparam int unsigned DW = 16;
   localparam int unsigned MB = 4;
   localparam int unsigned IW = 2;
`ifdef COBS_ARB_HEADER_EN
   localparam int unsigned HdrBeats = 1;
`else
   localparam int unsigned HdrBeats = 0;
`endif

   logic              clk;
   logic              rst;
   logic [NS*DW-1:0]  s_tdata;
   logic [NS-1:0]     s_tvalid;
   logic [NS-1:0]     s_tlast;
   logic [NS-1:0]     s_tready;
   logic [DW-1:0]     m_tdata;
   logic              m_tvalid;
   logic              m_tlast;
   logic              m_tready;
   logic [IW-1:0]     grant_id;
   logic              busy;
   logic              overflow;

   cobs_stream_arbiter #(
      .NUM_SOURCES (NS),
      .DATA_WIDTH  (DW),
      .MAX_BEATS   (MB),
      .ID_WIDTH    (IW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tlast  (s_tlast),
      .s_tready (s_tready),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tlast  (m_tlast),
      .m_tready (m_tready),
      .grant_id (grant_id),
      .busy     (busy),
      .overflow (overflow)
   );

   typedef struct packed {
      logic [IW-1:0] id;
      logic [DW-1:0] data;
      logic          last;
      logic          forced;
      logic          hdr;
   } exp_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   exp_t        exp_q[$];
   beat_t       src_q[NS][$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned n_beats  = 0;
   logic        bp_mode;
   logic        check_gap;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Source beats plus expected output, splitting at the beat limit like the arbiter must.
   task automatic push_pkt(input int unsigned id, input int unsigned n, input logic [DW-1:0] base);
      int unsigned cnt;
      exp_t        e;
      beat_t       b;
      cnt = 0;
      for (int unsigned k = 0; k < n; k++) begin
`ifdef COBS_ARB_HEADER_EN
         if (cnt == 0) begin
            e.id     = IW'(id);
            e.data   = {8'hA5, 8'(id)};
            e.last   = 1'b0;
            e.forced = 1'b0;
            e.hdr    = 1'b1;
            exp_q.push_back(e);
         end
`endif
         b.data = base + DW'(k);
         b.last = (k == n - 1);
         src_q[id].push_back(b);
         e.id     = IW'(id);
         e.data   = b.data;
         e.forced = !b.last && (cnt == MB - 1);
         e.last   = b.last || e.forced;
         e.hdr    = 1'b0;
         exp_q.push_back(e);
         cnt = e.last ? 0 : cnt + 1;
      end
   endtask

   task automatic wait_drain(input string tag);
      for (int c = 0; c < 300; c++) begin
         if (exp_q.size() == 0 && !busy) break;
         tick();
      end
      check_eq(tag, 32'(exp_q.size()), 0);
      check_eq({tag, "_busy"}, 32'(busy), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      for (int i = 0; i < NS; i++) src_q[i].delete();
      tick();
      tick();
      rst = 1'b0;
      check_eq("rst_valid", 32'(m_tvalid), 0);
      check_eq("rst_busy", 32'(busy), 0);
   endtask

   // Monitor samples at negedge; source driver updates just after posedge.
   initial begin : mon
      exp_t          e;
      logic [NS-1:0] fire;
      logic          in_gap;
      logic          ovf_wait;
      logic          prev_stall;
      logic [DW-1:0] prev_data;
      logic [31:0]   want_rdy;
      int unsigned   gap;
      fire = '0; in_gap = 1'b0; ovf_wait = 1'b0; prev_stall = 1'b0; prev_data = '0; gap = 0;
      s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            fire = '0; in_gap = 1'b0; ovf_wait = 1'b0; prev_stall = 1'b0;
         end else begin
            fire = s_tvalid & s_tready;
            if (ovf_wait) begin
               check_eq("overflow_rise", 32'(overflow), 1);
               ovf_wait = 1'b0;
            end
            if (m_tvalid) begin
               if (prev_stall) check_eq("stall_data", 32'(m_tdata), 32'(prev_data));
               if (in_gap) begin
                  if (check_gap) check_eq("gap_cycles", gap, 1);
                  in_gap = 1'b0;
               end
               if (exp_q.size() == 0) begin
                  check_eq("spurious_valid", 32'(m_tvalid), 0);
               end else begin
                  e = exp_q[0];
                  want_rdy = 0;
                  if (!e.hdr && m_tready) want_rdy = 32'(1) << e.id;
                  check_eq("grant_id", 32'(grant_id), 32'(e.id));
                  check_eq("s_tready", 32'(s_tready), want_rdy);
                  if (m_tready) begin
                     e = exp_q.pop_front();
                     check_eq("m_tdata", 32'(m_tdata), 32'(e.data));
                     check_eq("m_tlast", 32'(m_tlast), 32'(e.last));
                     n_beats++;
                     if (e.forced) begin
                        check_eq("overflow_pre", 32'(overflow), 0);
                        ovf_wait = 1'b1;
                     end
                     if (e.last) begin
                        in_gap = 1'b1;
                        gap = 0;
                     end
                  end
               end
               prev_stall = !m_tready;
               prev_data  = m_tdata;
            end else begin
               if (prev_stall) check_eq("stall_valid", 32'(m_tvalid), 1);
               prev_stall = 1'b0;
               if (in_gap) gap++;
            end
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < NS; i++) begin
            if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
               s_tvalid[i]          = 1'b1;
               s_tdata[i*DW +: DW]  = src_q[i][0].data;
               s_tlast[i]           = src_q[i][0].last;
            end else begin
               s_tvalid[i]          = 1'b0;
               s_tlast[i]           = 1'b0;
            end
         end
         m_tready = bp_mode ? ~m_tready : 1'b1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int unsigned target;
      rst = 1'b1;
      bp_mode = 1'b0;
      check_gap = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      check_eq("rst_m_tvalid", 32'(m_tvalid), 0);
      check_eq("rst_s_tready", 32'(s_tready), 0);
      check_eq("rst_busy0", 32'(busy), 0);
      check_eq("rst_overflow", 32'(overflow), 0);
      check_eq("rst_grant_id", 32'(grant_id), 0);

      // Single source, latency and grant hold.
      push_pkt(1, 3, 16'h6971);
      tick();
      check_eq("lat_idle", 32'(m_tvalid), 0);
      tick();
      check_eq("lat_first", 32'(m_tvalid), 1);
      wait_drain("t1_drain");
      check_eq("grant_hold", 32'(grant_id), 1);

      // Round robin with all sources continuously valid.
      do_reset();
      check_gap = 1'b1;
      push_pkt(0, 2, 16'h1000);
      push_pkt(1, 2, 16'h1100);
      push_pkt(2, 2, 16'h1200);
      push_pkt(3, 2, 16'h1300);
      push_pkt(0, 2, 16'h1010);
      wait_drain("t2_drain");
      check_gap = 1'b0;

      // Alternating backpressure.
      do_reset();
      bp_mode = 1'b1;
      push_pkt(2, 4, 16'h3000);
      wait_drain("t3_drain");
      bp_mode = 1'b0;

      // Beat limit forces tlast; overflow is sticky.
      do_reset();
      push_pkt(0, 6, 16'h4000);
      wait_drain("t4_drain");
      repeat (3) tick();
      check_eq("overflow_sticky", 32'(overflow), 1);

      // Reset mid-packet.
      target = n_beats + HdrBeats + 2;
      push_pkt(2, 5, 16'h5000);
      for (int c = 0; c < 100 && n_beats < target; c++) tick();
      check_eq("t5_reached", 32'(n_beats >= target), 1);
      rst = 1'b1;
      src_q[2].delete();
      exp_q.delete();
      tick();
      rst = 1'b0;
      check_eq("t5_valid", 32'(m_tvalid), 0);
      check_eq("t5_busy", 32'(busy), 0);
      check_eq("t5_overflow", 32'(overflow), 0);
      push_pkt(0, 1, 16'h5100);
      push_pkt(3, 1, 16'h5300);
      wait_drain("t5_drain");

`ifdef COBS_ARB_HEADER_EN
      // Channel header ahead of a one-beat packet.
      do_reset();
      push_pkt(3, 1, 16'h1234);
      wait_drain("t6_drain");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
